// File: rtl/crc16_pkg.sv
// Shared constants and state encoding for the bit-serial CRC-16 engine and its helpers.
package crc16_pkg;

  localparam int          CRC_W              = 16;
  localparam logic [15:0] CRC16_POLY_DEFAULT = 16'h8005;
  localparam logic [15:0] CRC16_INIT_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc16_bit_step.sv
// One-bit MSB-first CRC LFSR update; purely combinational so a parallel checker can chain copies.
module crc16_bit_step
  import crc16_pkg::*;
(
  input  logic [CRC_W-1:0] crc_i,
  input  logic             bit_i,
  input  logic [CRC_W-1:0] poly_i,
  output logic [CRC_W-1:0] crc_o
);

  logic fb;

  assign fb    = crc_i[CRC_W-1] ^ bit_i;
  assign crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ (fb ? poly_i : {CRC_W{1'b0}});

endmodule

// File: rtl/crc16_serial_engine.sv
// Bit-serial CRC-16 over a fixed-length MSB-first frame with a one-cycle Done pulse.
// Optional reference compare (Crc_ref/Crc_match) is built when CRC16_CHECK_EN is defined.
module crc16_serial_engine
  import crc16_pkg::*;
#(
  parameter int          FRAME_BITS = 20,
  parameter logic [15:0] POLY       = CRC16_POLY_DEFAULT,
  parameter logic [15:0] INIT       = CRC16_INIT_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Bit_in,
  input  logic             Bit_valid,
`ifdef CRC16_CHECK_EN
  input  logic [CRC_W-1:0] Crc_ref,
  output logic             Crc_match,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [CRC_W-1:0] Crc_out
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  crc_state_e       state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [CRC_W-1:0] crc_out_q;
  logic             match_q;
  logic             match_d;

  crc16_bit_step u_step (
    .crc_i  (crc_q),
    .bit_i  (Bit_in),
    .poly_i (POLY),
    .crc_o  (crc_d)
  );

`ifdef CRC16_CHECK_EN
  assign match_d   = (crc_d == Crc_ref);
  assign Crc_match = match_q;
`else
  assign match_d   = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      crc_out_q <= '0;
      match_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            crc_q   <= INIT;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (Start) begin
            crc_q <= INIT;
            cnt_q <= '0;
          end else if (Bit_valid) begin
            crc_q <= crc_d;
            if (cnt_q == LAST_CNT) begin
              // Result and pulse are captured on the last-bit edge so Done lands in the DONE cycle.
              cnt_q     <= '0;
              state_q   <= DONE;
              done_q    <= 1'b1;
              crc_out_q <= crc_d;
              match_q   <= match_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (Start) begin
            crc_q   <= INIT;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy    = (state_q == SHIFT);
  assign Done    = done_q;
  assign Crc_out = crc_out_q;

endmodule

// File: tb/tb_crc16_serial_engine.sv
// Scoreboard bench for crc16_serial_engine: three instances (FRAME_BITS = 1, 72, 20) on one clock.
// Compare port checks run when CRC16_CHECK_EN is defined.
module tb_crc16_serial_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = '0;
  logic [2:0]  bit_in = '0;
  logic [2:0]  bv = '0;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [15:0] crc_out [3];
`ifdef CRC16_CHECK_EN
  logic [15:0] crc_ref [3];
  logic [2:0]  match;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] crc;
    int          due;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];
  exp_t sbq2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc16_serial_engine #(.FRAME_BITS(1)) u_f1 (
    .Clk(clk), .Reset_n(rst_n), .Start(start[0]), .Bit_in(bit_in[0]), .Bit_valid(bv[0]),
`ifdef CRC16_CHECK_EN
    .Crc_ref(crc_ref[0]), .Crc_match(match[0]),
`endif
    .Busy(busy[0]), .Done(done[0]), .Crc_out(crc_out[0])
  );

  crc16_serial_engine #(.FRAME_BITS(72)) u_f72 (
    .Clk(clk), .Reset_n(rst_n), .Start(start[1]), .Bit_in(bit_in[1]), .Bit_valid(bv[1]),
`ifdef CRC16_CHECK_EN
    .Crc_ref(crc_ref[1]), .Crc_match(match[1]),
`endif
    .Busy(busy[1]), .Done(done[1]), .Crc_out(crc_out[1])
  );

  crc16_serial_engine #(.FRAME_BITS(20)) u_f20 (
    .Clk(clk), .Reset_n(rst_n), .Start(start[2]), .Bit_in(bit_in[2]), .Bit_valid(bv[2]),
`ifdef CRC16_CHECK_EN
    .Crc_ref(crc_ref[2]), .Crc_match(match[2]),
`endif
    .Busy(busy[2]), .Done(done[2]), .Crc_out(crc_out[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference CRC, MSB-first from bit n-1 down to bit 0, seed 0.
  function automatic logic [15:0] crc_model(input logic [127:0] d, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  task automatic sb_push(input int idx, input logic [15:0] c, input int due);
    exp_t e;
    e.crc = c;
    e.due = due;
    case (idx)
      0:       sbq0.push_back(e);
      1:       sbq1.push_back(e);
      default: sbq2.push_back(e);
    endcase
  endtask

  // Drives n bits MSB-first with random stalls; starts right after a negedge, ends after one.
  task automatic send_bits(input int idx, input int n, input logic [127:0] d,
                           input int gap_pct, input logic [15:0] expc, input bit push);
    for (int i = n - 1; i >= 0; i--) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        bv[idx]     = 1'b0;
        bit_in[idx] = 1'($urandom);
        @(negedge clk);
      end
      bv[idx]     = 1'b1;
      bit_in[idx] = d[i];
      if (i == 0 && push) sb_push(idx, expc, cyc + 1);
      @(negedge clk);
    end
    bv[idx] = 1'b0;
  endtask

  task automatic start_pulse(input int idx);
    @(negedge clk);
    start[idx] = 1'b1;
    bv[idx]    = 1'b0;
    @(negedge clk);
    start[idx] = 1'b0;
  endtask

  task automatic send_frame(input int idx, input int n, input logic [127:0] d,
                            input int gap_pct, input logic [15:0] expc);
    start_pulse(idx);
    send_bits(idx, n, d, gap_pct, expc, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic sb_check(input int idx);
    exp_t e;
    int   sz;
    case (idx)
      0:       sz = sbq0.size();
      1:       sz = sbq1.size();
      default: sz = sbq2.size();
    endcase
    if (sz == 0) begin
      check($sformatf("spurious_done_i%0d", idx), 32'd1, 32'd0);
      return;
    end
    case (idx)
      0:       e = sbq0.pop_front();
      1:       e = sbq1.pop_front();
      default: e = sbq2.pop_front();
    endcase
    $display("done inst=%0d crc=%04h exp=%04h cyc=%0d", idx, crc_out[idx], e.crc, cyc);
    check($sformatf("crc_i%0d", idx), 32'(crc_out[idx]), 32'(e.crc));
    check($sformatf("done_lat_i%0d", idx), 32'(cyc), 32'(e.due));
    check($sformatf("busy_in_done_i%0d", idx), 32'(busy[idx]), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (done[i]) sb_check(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] ascii;
    logic [127:0] d;
    logic [15:0]  e;
    ascii = 128'h313233343536373839;
`ifdef CRC16_CHECK_EN
    for (int i = 0; i < 3; i++) crc_ref[i] = 16'h0000;
`endif

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy_i%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_done_i%0d", i), 32'(done[i]), 32'd0);
      check($sformatf("rst_crc_i%0d", i), 32'(crc_out[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-bit frame, then a back-to-back frame started during DONE.
    send_frame(0, 1, 128'h1, 0, 16'h8005);
    check("busy_after_done_f1", 32'(busy[0]), 32'd0);
    start_pulse(0);
    bv[0] = 1'b1; bit_in[0] = 1'b1; sb_push(0, 16'h8005, cyc + 1);
    @(negedge clk);
    bv[0] = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; bv[0] = 1'b1; bit_in[0] = 1'b0; sb_push(0, 16'h0000, cyc + 1);
    @(negedge clk);
    bv[0] = 1'b0;
    repeat (3) @(negedge clk);

    // "123456789": continuous and with random stalls.
    send_frame(1, 72, ascii, 0, 16'hFEE8);
    send_frame(1, 72, ascii, 35, 16'hFEE8);

    // All-zero 20-bit frame, then an aborted frame followed by a clean restart.
    send_frame(2, 20, 128'h0, 0, 16'h0000);
    start_pulse(2);
    send_bits(2, 10, 128'h3A5, 0, 16'h0000, 1'b0);
    start[2] = 1'b1; bv[2] = 1'b1; bit_in[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0; bv[2] = 1'b0;
    d = 128'($urandom_range(1, 20'hFFFFF));
    e = crc_model(d, 20);
    send_bits(2, 20, d, 20, e, 1'b1);
    repeat (3) @(negedge clk);

    // A few random frames against the reference model.
    for (int k = 0; k < 3; k++) begin
      d = 128'($urandom_range(0, 20'hFFFFF));
      send_frame(2, 20, d, 25, crc_model(d, 20));
    end
    d = 128'h8000F;
    send_frame(2, 20, d, 0, crc_model(d, 20));

    // Asynchronous reset mid-frame.
    start_pulse(2);
    send_bits(2, 5, 128'h15, 0, 16'h0000, 1'b0);
    check("busy_mid_frame", 32'(busy[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy[2]), 32'd0);
    check("arst_done", 32'(done[2]), 32'd0);
    check("arst_crc_i2", 32'(crc_out[2]), 32'd0);
    check("arst_crc_i1", 32'(crc_out[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d = 128'hC0FFE;
    send_frame(2, 20, d, 10, crc_model(d, 20));

`ifdef CRC16_CHECK_EN
    crc_ref[1] = 16'hFEE8;
    send_frame(1, 72, ascii, 0, 16'hFEE8);
    check("match_good", 32'(match[1]), 32'd1);
    crc_ref[1] = 16'hFEE9;
    send_frame(1, 72, ascii, 0, 16'hFEE8);
    check("match_bad", 32'(match[1]), 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("sb_left_i0", 32'(sbq0.size()), 32'd0);
    check("sb_left_i1", 32'(sbq1.size()), 32'd0);
    check("sb_left_i2", 32'(sbq2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
